// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: access-width codes, byte lanes and default widths.
package mips_pkg;

  localparam int unsigned NB_DATA_DFLT = 32;
  localparam int unsigned NB_ADDR_DFLT = 8;
  localparam int unsigned NB_REG_DFLT  = 5;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  // Byte accesses never fault; halves need an even lane; words (10/11) need lane 0.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
    case (width)
      WIDTH_BYTE: return 1'b0;
      WIDTH_HALF: return lane[0];
      default:    return lane != LANE_0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled for port connection.
interface mem_stage_if
  import mips_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DFLT,
  parameter int unsigned NB_ADDR = NB_ADDR_DFLT,
  parameter int unsigned NB_REG  = NB_REG_DFLT
);
  logic               i_halt;
  logic               i_mem2reg;
  logic               i_memRead;
  logic               i_memWrite;
  logic               i_regWrite;
  logic [1:0]         i_width;
  logic               i_sign_flag;
  logic [NB_REG-1:0]  i_write_reg;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] i_data4Mem;
  logic [NB_ADDR-1:0] i_dbg_addr;
  logic [NB_DATA-1:0] o_dbg_data;
  logic               o_mem2reg;
  logic               o_regWrite;
  logic [NB_REG-1:0]  o_write_reg;
  logic [NB_DATA-1:0] o_mem_data;
  logic [NB_DATA-1:0] o_alu_result;
  logic [NB_DATA-1:0] o_wb_data;
  logic               o_misaligned;

  modport master (
    output i_halt, i_mem2reg, i_memRead, i_memWrite, i_regWrite, i_width, i_sign_flag,
           i_write_reg, i_result, i_data4Mem, i_dbg_addr,
    input  o_dbg_data, o_mem2reg, o_regWrite, o_write_reg, o_mem_data, o_alu_result,
           o_wb_data, o_misaligned
  );

  modport slave (
    input  i_halt, i_mem2reg, i_memRead, i_memWrite, i_regWrite, i_width, i_sign_flag,
           i_write_reg, i_result, i_data4Mem, i_dbg_addr,
    output o_dbg_data, o_mem2reg, o_regWrite, o_write_reg, o_mem_data, o_alu_result,
           o_wb_data, o_misaligned
  );
endinterface

// File: rtl/data_memory_bytewise.sv
// Word-organised data memory with per-byte write enables and two combinational read ports.
module data_memory_bytewise
  import mips_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DFLT,
  parameter int unsigned NB_ADDR = NB_ADDR_DFLT
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [NB_DATA/8-1:0] be,
  input  logic [NB_ADDR-1:0]   addr,
  input  logic [NB_DATA-1:0]   wdata,
  output logic [NB_DATA-1:0]   rdata,
  input  logic [NB_ADDR-1:0]   dbg_addr,
  output logic [NB_DATA-1:0]   dbg_data
);
  localparam int unsigned NB_BYTES = NB_DATA / 8;

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB_BYTES; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata    = mem[addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: sub-word store steering, load alignment/extension and the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DFLT,
  parameter int unsigned NB_ADDR = NB_ADDR_DFLT,
  parameter int unsigned NB_REG  = NB_REG_DFLT
) (
  input  logic   clk,
  input  logic   i_reset,
  mem_stage_if.slave bus
);
  localparam int unsigned NB_BYTES = NB_DATA / 8;

  logic [NB_ADDR-1:0]  word_idx;
  logic [1:0]          lane;
  logic                misaligned;
  logic                we;
  logic [NB_BYTES-1:0] be;
  logic [NB_DATA-1:0]  wdata;
  logic [NB_DATA-1:0]  rdata;
  logic [15:0]         lane_half;
  logic [NB_DATA-1:0]  load_data;
  logic                unused_upper_addr;

  logic               mem2reg_q, regwrite_q, misaligned_q;
  logic [NB_REG-1:0]  write_reg_q;
  logic [NB_DATA-1:0] mem_data_q, alu_result_q;

  assign word_idx          = bus.i_result[NB_ADDR+1:2];
  assign lane              = bus.i_result[1:0];
  assign unused_upper_addr = ^bus.i_result[NB_DATA-1:NB_ADDR+2];
  assign misaligned        = is_misaligned(bus.i_width, lane);
  assign we                = bus.i_memWrite & ~misaligned & ~bus.i_halt;

  // Replicate sub-word store data across lanes; the byte enables pick the target lane(s).
  always_comb begin
    be    = '1;
    wdata = bus.i_data4Mem;
    case (bus.i_width)
      WIDTH_BYTE: begin
        be    = {{(NB_BYTES-1){1'b0}}, 1'b1} << lane;
        wdata = {NB_BYTES{bus.i_data4Mem[7:0]}};
      end
      WIDTH_HALF: begin
        be    = {{(NB_BYTES-2){1'b0}}, 2'b11} << lane;
        wdata = {(NB_BYTES/2){bus.i_data4Mem[15:0]}};
      end
      default: ;
    endcase
  end

  data_memory_bytewise #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_dmem (
    .clk      (clk),
    .we       (we),
    .be       (be),
    .addr     (word_idx),
    .wdata    (wdata),
    .rdata    (rdata),
    .dbg_addr (bus.i_dbg_addr),
    .dbg_data (bus.o_dbg_data)
  );

  assign lane_half = 16'(rdata >> {lane, 3'b000});

  always_comb begin
    case (bus.i_width)
      WIDTH_BYTE: load_data = {{(NB_DATA-8){bus.i_sign_flag & lane_half[7]}}, lane_half[7:0]};
      WIDTH_HALF: load_data = {{(NB_DATA-16){bus.i_sign_flag & lane_half[15]}}, lane_half};
      default:    load_data = rdata;
    endcase
    if (misaligned) load_data = '0;
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      mem2reg_q    <= 1'b0;
      regwrite_q   <= 1'b0;
      misaligned_q <= 1'b0;
      write_reg_q  <= '0;
      mem_data_q   <= '0;
      alu_result_q <= '0;
    end else if (!bus.i_halt) begin
      mem2reg_q    <= bus.i_mem2reg;
      regwrite_q   <= bus.i_regWrite & ~(bus.i_memRead & misaligned);
      misaligned_q <= (bus.i_memRead | bus.i_memWrite) & misaligned;
      write_reg_q  <= bus.i_write_reg;
      mem_data_q   <= load_data;
      alu_result_q <= bus.i_result;
    end
  end

  assign bus.o_mem2reg    = mem2reg_q;
  assign bus.o_regWrite   = regwrite_q;
  assign bus.o_misaligned = misaligned_q;
  assign bus.o_write_reg  = write_reg_q;
  assign bus.o_mem_data   = mem_data_q;
  assign bus.o_alu_result = alu_result_q;
  assign bus.o_wb_data    = mem2reg_q ? mem_data_q : alu_result_q;

endmodule
